tinyalu_requester: RTL and testbench

Initiator-side controller for the tinyalu start/done protocol. It accepts ALU commands from an upstream valid/ready port and drives operands, opcode and `start` into the ALU. It holds `start` until `done`, captures the result and presents it on a downstream valid/ready response port. It also guards against a missing `done` with a cycle timeout, and handles no-op and illegal opcodes locally without starting the ALU.

---
 rtl/tinyalu_pkg.sv | 23 ++
 rtl/tinyalu_requester_timer.sv | 36 +++
 rtl/tinyalu_requester.sv | 121 ++++++++++++
 tb/tb_tinyalu_requester.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// Shared types for the tinyalu requester: opcodes, FSM states and opcode legality.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100
    } operation_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } requester_state_t;

    // Encodings above MUL have no ALU operation behind them.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'b100);
    endfunction

endpackage

// File: rtl/tinyalu_requester_timer.sv
// ISSUE-state watchdog: clear/enable up-counter flagging the last allowed cycle.
module req_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/tinyalu_requester.sv
// Initiator for the tinyalu start/done handshake: command in, ALU drive, response out,
// with a done-timeout and local handling of NOP and illegal opcodes.
module tinyalu_requester
    import tinyalu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic        rsp_timeout
);

    requester_state_t state_q;
    logic [7:0]  alu_a_q, alu_b_q;
    logic [2:0]  alu_op_q, rsp_op_q;
    logic        alu_start_q, rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic [15:0] rsp_result_q;
    logic        accept;
    logic        timer_expired;

    // Holding off while done is high keeps a stale completion from aliasing onto a new start.
    assign cmd_ready = (state_q == IDLE) && !alu_done;
    assign accept    = cmd_valid && cmd_ready;

    req_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk       (clk),
        .rst       (reset),
        .clr_i     (accept),
        .en_i      ((state_q == ISSUE) && !alu_done),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            alu_start_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_op_q      <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rsp_op_q      <= cmd_op;
                        rsp_result_q  <= '0;
                        rsp_err_q     <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        if (cmd_op == OP_NOP) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else if (!is_legal_op(cmd_op)) begin
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            alu_a_q     <= cmd_a;
                            alu_b_q     <= cmd_b;
                            alu_op_q    <= cmd_op;
                            alu_start_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (alu_done) begin
                        alu_start_q   <= 1'b0;
                        rsp_result_q  <= alu_result;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else if (timer_expired) begin
                        alu_start_q   <= 1'b0;
                        rsp_result_q  <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign alu_start   = alu_start_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_tinyalu_requester.sv
// Directed bench for tinyalu_requester; the ALU side is driven by hand cycle by cycle.
module tb_tinyalu_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        rsp_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tinyalu_requester #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_op      (rsp_op),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if ({alu_start, rsp_valid, rsp_err, rsp_timeout} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b exp 0000", {alu_start, rsp_valid, rsp_err, rsp_timeout});
        end
        total++;
        if ({alu_a, alu_b, alu_op, rsp_op, rsp_result} !== 38'd0) begin
            bad++;
            $display("FAIL reset_data: got %h exp 0", {alu_a, alu_b, alu_op, rsp_op, rsp_result});
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_add_single_cycle();
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_a = 8'h0F; cmd_b = 8'h01;
        step();
        cmd_valid = 1'b0;
        total++;
        if ({alu_start, rsp_valid, cmd_ready} !== 3'b100) begin
            bad++;
            $display("FAIL add_issue_flags: got %b exp 100", {alu_start, rsp_valid, cmd_ready});
        end
        total++;
        if ({alu_a, alu_b, alu_op} !== {8'h0F, 8'h01, 3'b001}) begin
            bad++;
            $display("FAIL add_operands: got %h exp %h", {alu_a, alu_b, alu_op}, {8'h0F, 8'h01, 3'b001});
        end
        alu_done = 1'b1; alu_result = 16'h0010;
        step();
        total++;
        if ({alu_start, rsp_valid, rsp_err, rsp_timeout} !== 4'b0100) begin
            bad++;
            $display("FAIL add_rsp_flags: got %b exp 0100", {alu_start, rsp_valid, rsp_err, rsp_timeout});
        end
        total++;
        if ({rsp_result, rsp_op} !== {16'h0010, 3'b001}) begin
            bad++;
            $display("FAIL add_rsp_data: got %h exp %h", {rsp_result, rsp_op}, {16'h0010, 3'b001});
        end
        // second done from a single-cycle ALU must be ignored in RESP
        alu_result = 16'hDEAD;
        step();
        total++;
        if ({rsp_valid, alu_start, cmd_ready, rsp_result} !== {3'b100, 16'h0010}) begin
            bad++;
            $display("FAIL add_second_done: got %h exp %h", {rsp_valid, alu_start, cmd_ready, rsp_result}, {3'b100, 16'h0010});
        end
        alu_done = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            bad++;
            $display("FAIL add_drain: got %b exp 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_mul_multi_cycle();
        cmd_valid = 1'b1; cmd_op = 3'b100; cmd_a = 8'hFF; cmd_b = 8'hFF;
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({alu_start, rsp_valid} !== 2'b10) begin
                bad++;
                $display("FAIL mul_busy[%0d]: got %b exp 10", k, {alu_start, rsp_valid});
            end
            step();
        end
        alu_done = 1'b1; alu_result = 16'hFE01;
        step();
        total++;
        if ({alu_start, rsp_valid, rsp_result, rsp_op} !== {2'b01, 16'hFE01, 3'b100}) begin
            bad++;
            $display("FAIL mul_rsp: got %h exp %h", {alu_start, rsp_valid, rsp_result, rsp_op}, {2'b01, 16'hFE01, 3'b100});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b00) begin
            bad++;
            $display("FAIL mul_ready_while_done: got %b exp 00", {rsp_valid, cmd_ready});
        end
        alu_done = 1'b0;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL mul_ready_after_done_low: got %b exp 1", cmd_ready);
        end
        step();
    endtask

    task automatic test_nop_illegal();
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 8'h55; cmd_b = 8'hAA;
        step();
        cmd_valid = 1'b0;
        total++;
        if ({alu_start, rsp_valid, rsp_err, rsp_timeout, rsp_result, rsp_op} !== {4'b0100, 16'h0000, 3'b000}) begin
            bad++;
            $display("FAIL nop_rsp: got %h exp %h", {alu_start, rsp_valid, rsp_err, rsp_timeout, rsp_result, rsp_op}, {4'b0100, 16'h0000, 3'b000});
        end
        total++;
        if ({alu_a, alu_b, alu_op} !== {8'hFF, 8'hFF, 3'b100}) begin
            bad++;
            $display("FAIL nop_alu_hold: got %h exp %h", {alu_a, alu_b, alu_op}, {8'hFF, 8'hFF, 3'b100});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 3'b110;
        step();
        cmd_valid = 1'b0;
        total++;
        if ({alu_start, rsp_valid, rsp_err, rsp_timeout, rsp_result, rsp_op} !== {4'b0110, 16'h0000, 3'b110}) begin
            bad++;
            $display("FAIL illegal_rsp: got %h exp %h", {alu_start, rsp_valid, rsp_err, rsp_timeout, rsp_result, rsp_op}, {4'b0110, 16'h0000, 3'b110});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, alu_start} !== 2'b00) begin
            bad++;
            $display("FAIL illegal_drain: got %b exp 00", {rsp_valid, alu_start});
        end
    endtask

    task automatic test_timeout();
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_a = 8'h03; cmd_b = 8'h04;
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k < 16; k++) begin
            step();
            total++;
            if ({rsp_valid, alu_start} !== 2'b01) begin
                bad++;
                $display("FAIL timeout_wait[%0d]: got %b exp 01", k, {rsp_valid, alu_start});
            end
        end
        step();
        total++;
        if ({rsp_valid, rsp_timeout, alu_start, rsp_err, rsp_result} !== {4'b1100, 16'h0000}) begin
            bad++;
            $display("FAIL timeout_rsp: got %h exp %h", {rsp_valid, rsp_timeout, alu_start, rsp_err, rsp_result}, {4'b1100, 16'h0000});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_a = 8'h10; cmd_b = 8'h20;
        step();
        cmd_op = 3'b010;
        alu_done = 1'b1; alu_result = 16'h0030;
        step();
        alu_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            total++;
            if ({rsp_valid, cmd_ready, rsp_timeout, rsp_op, rsp_result} !== {3'b100, 3'b001, 16'h0030}) begin
                bad++;
                $display("FAIL backpressure[%0d]: got %h exp %h", k, {rsp_valid, cmd_ready, rsp_timeout, rsp_op, rsp_result}, {3'b100, 3'b001, 16'h0030});
            end
            step();
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 8'hF0; cmd_b = 8'h3C;
        rsp_ready = 1'b1;
        step();
        alu_done = 1'b1; alu_result = 16'h00CC;
        cmd_a = 8'h0F; cmd_b = 8'h0F;
        step();
        total++;
        if ({rsp_valid, rsp_result, cmd_ready} !== {1'b1, 16'h00CC, 1'b0}) begin
            bad++;
            $display("FAIL b2b_first_rsp: got %h exp %h", {rsp_valid, rsp_result, cmd_ready}, {1'b1, 16'h00CC, 1'b0});
        end
        step();
        alu_done = 1'b0;
        #1;
        total++;
        if ({rsp_valid, cmd_ready, alu_a} !== {2'b01, 8'hF0}) begin
            bad++;
            $display("FAIL b2b_idle_gap: got %h exp %h", {rsp_valid, cmd_ready, alu_a}, {2'b01, 8'hF0});
        end
        step();
        cmd_valid = 1'b0;
        total++;
        if ({alu_start, alu_a, alu_b} !== {1'b1, 8'h0F, 8'h0F}) begin
            bad++;
            $display("FAIL b2b_second_issue: got %h exp %h", {alu_start, alu_a, alu_b}, {1'b1, 8'h0F, 8'h0F});
        end
        alu_done = 1'b1; alu_result = 16'h0000;
        step();
        alu_done = 1'b0;
        total++;
        if ({rsp_valid, rsp_result} !== {1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL b2b_second_rsp: got %h exp %h", {rsp_valid, rsp_result}, {1'b1, 16'h0000});
        end
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        cmd_valid = 1'b1; cmd_op = 3'b100; cmd_a = 8'h02; cmd_b = 8'h03;
        step();
        cmd_valid = 1'b0;
        step();
        total++;
        if (alu_start !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: got %b exp 1", alu_start);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({alu_start, rsp_valid, rsp_err, rsp_timeout, alu_a, alu_b, alu_op, rsp_op, rsp_result} !== 42'd0) begin
            bad++;
            $display("FAIL rst_mid_async: got %h exp 0", {alu_start, rsp_valid, rsp_err, rsp_timeout, alu_a, alu_b, alu_op, rsp_op, rsp_result});
        end
        step();
        reset = 1'b0;
        alu_done = 1'b1; alu_result = 16'h0006;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if ({rsp_valid, alu_start} !== 2'b00) begin
                bad++;
                $display("FAIL rst_no_rsp[%0d]: got %b exp 00", k, {rsp_valid, alu_start});
            end
        end
        alu_done = 1'b0;
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_a = 8'h07; cmd_b = 8'h08;
        step();
        cmd_valid = 1'b0;
        step();
        alu_done = 1'b1; alu_result = 16'h000F;
        step();
        alu_done = 1'b0;
        total++;
        if ({rsp_valid, rsp_result, rsp_op, rsp_err, rsp_timeout} !== {1'b1, 16'h000F, 3'b001, 2'b00}) begin
            bad++;
            $display("FAIL rst_after_add: got %h exp %h", {rsp_valid, rsp_result, rsp_op, rsp_err, rsp_timeout}, {1'b1, 16'h000F, 3'b001, 2'b00});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        alu_done = 1'b0; alu_result = '0;
        rsp_ready = 1'b0;
        #2;
        test_reset();
        test_add_single_cycle();
        test_mul_multi_cycle();
        test_nop_illegal();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
